mt9d111_pixel_capture: RTL

// - Upstream stage of the video path. Runs in the MT9D111 pixel-clock domain.
// - Turns the sensor's 8-bit DVP byte stream (VSYNC/HREF/D) into RGB565 pixel strobes.
// - Outputs: FrameData, FrameDataEn, FrameHCnt, FrameVCnt and FrameNewEn. The camera-to-DDR

---
 rtl/mt9d111_pixel_capture_pkg.sv | 27 ++
 rtl/mt9d111_pixel_capture_edge_det.sv | 24 ++
 rtl/mt9d111_pixel_capture.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mt9d111_pixel_capture_pkg.sv
// Purpose : shared constants, state encoding and pixel packing helper for the
//           MT9D111 DVP pixel capture block.
// Contents: default accepted frame geometry, counter width, capture FSM states,
//           RGB565 byte-pair packing function.
package mt9d111_pixel_capture_pkg;

    // Accepted frame geometry (sensor output window)
    localparam int CAM_H_WIDTH_DEF  = 1600;
    localparam int CAM_V_HEIGHT_DEF = 1200;

    // Width of HCnt / VCnt / line counters
    localparam int CNT_W = 11;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        VBLANK = 2'd1,
        ACTIVE = 2'd2
    } cap_state_e;

    // Combine the two bytes of a pixel in arrival order into RGB565.
    function automatic logic [15:0] pack_rgb565(input logic [7:0] first_byte,
                                                input logic [7:0] second_byte,
                                                input logic       hi_first);
        return hi_first ? {first_byte, second_byte} : {second_byte, first_byte};
    endfunction

endpackage

// File: rtl/mt9d111_pixel_capture_edge_det.sv
// Purpose : registers a level once and reports its rising / falling edges.
// Ports   : clk    - sampling clock
//           i_lvl  - level to watch (already synchronous to clk)
//           o_rise - high in the cycle i_lvl is 1 and was 0 on the previous edge
//           o_fall - high in the cycle i_lvl is 0 and was 1 on the previous edge
module dvp_edge_det (
    input  logic clk,
    input  logic i_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic r_lvl;

    // Deliberately not reset: the register keeps tracking the input during
    // reset, so a level already asserted at reset release gives no edge.
    always_ff @(posedge clk) begin
        r_lvl <= i_lvl;
    end

    assign o_rise = i_lvl & ~r_lvl;
    assign o_fall = ~i_lvl & r_lvl;

endmodule

// File: rtl/mt9d111_pixel_capture.sv
// Purpose : converts the MT9D111 8-bit DVP stream (VSYNC/HREF/D) into RGB565
//           pixel strobes with 1-based column and 0-based row counters, plus
//           per-frame line count and sticky error status.
// Ports   : MT9D111_CLK         - sensor pixel clock (only clock)
//           sys_rst             - synchronous reset, active-high
//           CAP_EN              - capture enable, sampled at frame start
//           CAM_VSYNC/CAM_HREF  - sensor sync signals, synchronous to MT9D111_CLK
//           CAM_D               - sensor data byte
//           MT9D111_FrameData   - RGB565 pixel (holds between strobes)
//           MT9D111_FrameDataEn - one-cycle pixel strobe
//           MT9D111_FrameHCnt   - column of the pixel, 1-based
//           MT9D111_FrameVCnt   - row of the pixel, 0-based
//           MT9D111_FrameNewEn  - one-cycle pulse when a captured frame starts
//           FRAME_LINES         - line count of the last completed frame
//           CAP_ERR             - sticky {odd_byte, line_overflow, frame_overflow}
module mt9d111_pixel_capture
    import mt9d111_pixel_capture_pkg::*;
#(
    parameter int CAM_H_WIDTH   = CAM_H_WIDTH_DEF,
    parameter int CAM_V_HEIGHT  = CAM_V_HEIGHT_DEF,
    parameter bit VS_POL        = 1'b1,
    parameter bit BYTE_HI_FIRST = 1'b1
) (
    input  logic             MT9D111_CLK,
    input  logic             sys_rst,
    input  logic             CAP_EN,
    input  logic             CAM_VSYNC,
    input  logic             CAM_HREF,
    input  logic [7:0]       CAM_D,
    output logic [15:0]      MT9D111_FrameData,
    output logic             MT9D111_FrameDataEn,
    output logic [CNT_W-1:0] MT9D111_FrameHCnt,
    output logic [CNT_W-1:0] MT9D111_FrameVCnt,
    output logic             MT9D111_FrameNewEn,
    output logic [CNT_W-1:0] FRAME_LINES,
    output logic [2:0]       CAP_ERR
);

    logic w_vs_act, w_vs_rise, w_vs_fall, w_href_fall;

    assign w_vs_act = (CAM_VSYNC == VS_POL);

    dvp_edge_det u_vs_edge (
        .clk    (MT9D111_CLK),
        .i_lvl  (w_vs_act),
        .o_rise (w_vs_rise),
        .o_fall (w_vs_fall)
    );

    logic w_href_rise_unused;

    dvp_edge_det u_href_edge (
        .clk    (MT9D111_CLK),
        .i_lvl  (CAM_HREF),
        .o_rise (w_href_rise_unused),
        .o_fall (w_href_fall)
    );

    cap_state_e r_state, w_state_nxt;
    logic       w_frame_start, w_frame_end;

    always_ff @(posedge MT9D111_CLK) begin
        if (sys_rst) r_state <= SYNC;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        case (r_state)
            // Wait for a full VSYNC so the first captured frame is complete
            SYNC: if (w_vs_rise) w_state_nxt = VBLANK;
            VBLANK: begin
                if (w_vs_fall && CAP_EN) begin
                    w_state_nxt   = ACTIVE;
                    w_frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_vs_rise) begin
                    w_state_nxt = VBLANK;
                    w_frame_end = 1'b1;
                end
            end
            default: w_state_nxt = SYNC;
        endcase
    end

    logic             r_phase;
    logic [7:0]       r_byte;
    logic [CNT_W-1:0] r_line_pix;
    logic [CNT_W-1:0] r_line_cnt;

    logic             w_byte_en, w_line_end, w_h_ok, w_v_ok;
    logic [CNT_W:0]   w_hcnt_nxt;
    logic [CNT_W-1:0] w_line_cnt_nxt;

    assign w_byte_en  = (r_state == ACTIVE) && CAM_HREF;
    assign w_line_end = (r_state == ACTIVE) && w_href_fall;
    assign w_hcnt_nxt = {1'b0, r_line_pix} + 1'b1;
    assign w_h_ok     = (w_hcnt_nxt <= (CNT_W+1)'(CAM_H_WIDTH));
    assign w_v_ok     = (r_line_cnt < CNT_W'(CAM_V_HEIGHT));

    // A line counts only if it produced a pixel; counter saturates rather than wraps
    assign w_line_cnt_nxt = ((r_line_pix != '0) && (r_line_cnt != '1)) ?
                            r_line_cnt + 1'b1 : r_line_cnt;

    always_ff @(posedge MT9D111_CLK) begin
        if (sys_rst) begin
            r_phase             <= 1'b0;
            r_byte              <= '0;
            r_line_pix          <= '0;
            r_line_cnt          <= '0;
            MT9D111_FrameData   <= '0;
            MT9D111_FrameDataEn <= 1'b0;
            MT9D111_FrameHCnt   <= '0;
            MT9D111_FrameVCnt   <= '0;
            MT9D111_FrameNewEn  <= 1'b0;
            FRAME_LINES         <= '0;
            CAP_ERR             <= '0;
        end else begin
            MT9D111_FrameDataEn <= 1'b0;
            MT9D111_FrameNewEn  <= 1'b0;
            if (w_frame_start) begin
                MT9D111_FrameNewEn <= 1'b1;
                CAP_ERR            <= '0;
                r_phase            <= 1'b0;
                r_line_pix         <= '0;
                r_line_cnt         <= '0;
                MT9D111_FrameVCnt  <= '0;
            end else begin
                if (w_byte_en) begin
                    if (!r_phase) begin
                        r_byte  <= CAM_D;
                        r_phase <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        if (r_line_pix != '1) r_line_pix <= r_line_pix + 1'b1;
                        if (!w_v_ok) begin
                            CAP_ERR[0] <= 1'b1;
                        end else if (!w_h_ok) begin
                            CAP_ERR[1] <= 1'b1;
                        end else begin
                            MT9D111_FrameDataEn <= 1'b1;
                            MT9D111_FrameData   <= pack_rgb565(r_byte, CAM_D, BYTE_HI_FIRST);
                            MT9D111_FrameHCnt   <= w_hcnt_nxt[CNT_W-1:0];
                            MT9D111_FrameVCnt   <= r_line_cnt;
                        end
                    end
                end
                if (w_line_end) begin
                    r_line_pix <= '0;
                    r_line_cnt <= w_line_cnt_nxt;
                    // Dangling first byte of an unfinished pixel is discarded
                    if (r_phase) begin
                        CAP_ERR[2] <= 1'b1;
                        r_phase    <= 1'b0;
                    end
                end
                // A line ending on the same edge as the frame is counted first
                if (w_frame_end) begin
                    FRAME_LINES <= w_line_end ? w_line_cnt_nxt : r_line_cnt;
                end
            end
        end
    end

endmodule
